// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: control width and opcode encodings.
// Imported by the interface, the ALU and the testbench.
package alu_pkg;

  localparam int ALU_CTRL_W = 3;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b101;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 3'b110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 3'b111;

endpackage : alu_pkg

// File: rtl/alu_if.sv
// Operand/result bundle between the operand muxes (master) and the ALU (slave).
// Result and flags are registered inside the ALU.
interface alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0]      A;
  logic [WIDTH-1:0]      B;
  logic [ALU_CTRL_W-1:0] ALUControl;
  logic [WIDTH-1:0]      Result;
  logic                  Carry;
  logic                  OverFlow;
  logic                  Zero;
  logic                  Negative;

  modport master (
    output A, B, ALUControl,
    input  Result, Carry, OverFlow, Zero, Negative
  );

  modport slave (
    input  A, B, ALUControl,
    output Result, Carry, OverFlow, Zero, Negative
  );

endinterface : alu_if

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor shared by ADD, SUB and SLT.
// Subtraction is a + ~b + 1, so cout is the "no borrow" flag.
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff = b ^ {WIDTH{sub}};
  assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

  // Signed overflow: both addends share a sign that the sum does not.
  assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule : alu_addsub

// File: rtl/alu.sv
// 32-bit execute-stage ALU: operation mux plus flag logic, all outputs registered
// with one cycle of latency and a synchronous active-high reset.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] as_sum;
  logic             as_cout;
  logic             as_ovf;
  logic             as_sub;
  logic [SHW-1:0]   shamt;

  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             ovf_d;

  // SLT rides the subtract path; ADD is the only op that adds.
  assign as_sub = (bus.ALUControl == ALU_SUB) || (bus.ALUControl == ALU_SLT);
  assign shamt  = bus.B[SHW-1:0];

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (bus.A),
    .b    (bus.B),
    .sub  (as_sub),
    .sum  (as_sum),
    .cout (as_cout),
    .ovf  (as_ovf)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned and a latch is never inferred.
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    unique case (bus.ALUControl)
      ALU_ADD, ALU_SUB: begin
        res_d   = as_sum;
        carry_d = as_cout;
        ovf_d   = as_ovf;
      end
      ALU_AND: res_d = bus.A & bus.B;
      ALU_OR:  res_d = bus.A | bus.B;
      ALU_XOR: res_d = bus.A ^ bus.B;
      ALU_SLT: res_d = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
      ALU_SLL: res_d = bus.A << shamt;
      ALU_SRL: res_d = bus.A >> shamt;
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      bus.Result   <= '0;
      bus.Carry    <= 1'b0;
      bus.OverFlow <= 1'b0;
      bus.Zero     <= 1'b0;
      bus.Negative <= 1'b0;
    end else begin
      bus.Result   <= res_d;
      bus.Carry    <= carry_d;
      bus.OverFlow <= ovf_d;
      bus.Zero     <= (res_d == '0);
      bus.Negative <= res_d[WIDTH-1];
    end
  end

endmodule : alu

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors with literal expectations plus a
// per-cycle comparison against an arithmetic reference model delayed by one cycle.
module tb_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_if #(.WIDTH(W)) bus ();

  alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Packed as {Result, C, V, Z, N}.
  typedef logic [W+3:0] out_t;

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got R=%h C%b V%b Z%b N%b, expected R=%h C%b V%b Z%b N%b",
               name, act[W+3:4], act[3], act[2], act[1], act[0],
               exp[W+3:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic out_t dut_out();
    return {bus.Result, bus.Carry, bus.OverFlow, bus.Zero, bus.Negative};
  endfunction

  // Reference model: plain wide/signed arithmetic, no adder structure.
  function automatic out_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op);
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic [63:0]  ua;
    logic [63:0]  ub;
    longint       sa;
    longint       sb;
    longint       sr;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      ALU_ADD: begin
        r  = a + b;
        c  = ((ua + ub) >> W) != 64'd0;
        sr = sa + sb;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      ALU_SUB: begin
        r  = a - b;
        c  = (a >= b);
        sr = sa - sb;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLL: r = a << b[4:0];
      ALU_SRL: r = a >> b[4:0];
      default: r = '0;
    endcase
    return {r, c, v, (r == '0), r[W-1]};
  endfunction

  // Compare process: expectation captured at each edge, checked on the falling edge.
  out_t exp_q;
  logic have_exp = 1'b0;

  always @(posedge clk) begin
    exp_q    <= rst ? '0 : model(bus.A, bus.B, bus.ALUControl);
    have_exp <= 1'b1;
  end

  always @(negedge clk) begin
    if (have_exp) check("model", dut_out(), exp_q);
  end

  // Apply one op just after an edge and return once it has been registered.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    bus.A          = a;
    bus.B          = b;
    bus.ALUControl = op;
    @(posedge clk);
    #1;
  endtask

  function automatic out_t lit(input logic [W-1:0] r, input logic c, input logic v,
                               input logic z, input logic n);
    return {r, c, v, z, n};
  endfunction

  initial begin
    bus.A          = '0;
    bus.B          = '0;
    bus.ALUControl = ALU_ADD;
    rst            = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_out(), '0);
    rst = 1'b0;

    // A=1, B=2 stepped through ADD..SLT.
    apply(32'd1, 32'd2, ALU_ADD); check("add_1_2", dut_out(), lit(32'd3, 0, 0, 0, 0));
    apply(32'd1, 32'd2, ALU_SUB); check("sub_1_2", dut_out(), lit(32'hFFFF_FFFF, 0, 0, 0, 1));
    apply(32'd1, 32'd2, ALU_AND); check("and_1_2", dut_out(), lit(32'd0, 0, 0, 1, 0));
    apply(32'd1, 32'd2, ALU_OR);  check("or_1_2",  dut_out(), lit(32'd3, 0, 0, 0, 0));
    apply(32'd1, 32'd2, ALU_XOR); check("xor_1_2", dut_out(), lit(32'd3, 0, 0, 0, 0));
    apply(32'd1, 32'd2, ALU_SLT); check("slt_1_2", dut_out(), lit(32'd1, 0, 0, 0, 0));

    // Arithmetic boundaries.
    apply(32'h7FFF_FFFF, 32'd1, ALU_ADD); check("add_ovf",   dut_out(), lit(32'h8000_0000, 0, 1, 0, 1));
    apply(32'hFFFF_FFFF, 32'd1, ALU_ADD); check("add_carry", dut_out(), lit(32'd0, 1, 0, 1, 0));
    apply(32'd5, 32'd5, ALU_SUB);         check("sub_eq",    dut_out(), lit(32'd0, 1, 0, 1, 0));
    apply(32'h8000_0000, 32'd1, ALU_SUB); check("sub_ovf",   dut_out(), lit(32'h7FFF_FFFF, 1, 1, 0, 0));
    apply(32'hFFFF_FFFF, 32'd1, ALU_SLT); check("slt_neg",   dut_out(), lit(32'd1, 0, 0, 0, 0));
    apply(32'd1, 32'hFFFF_FFFF, ALU_SLT); check("slt_pos",   dut_out(), lit(32'd0, 0, 0, 1, 0));

    // Shifts: full range, ignored upper bits of B, zero amount.
    apply(32'd1, 32'd31, ALU_SLL);               check("sll_31",  dut_out(), lit(32'h8000_0000, 0, 0, 0, 1));
    apply(32'h8000_0000, 32'h21, ALU_SRL);       check("srl_hi",  dut_out(), lit(32'h4000_0000, 0, 0, 0, 0));
    apply(32'hDEAD_BEEF, 32'h0, ALU_SLL);        check("sll_0",   dut_out(), lit(32'hDEAD_BEEF, 0, 0, 0, 1));
    apply(32'hF000_0000, 32'd28, ALU_SRL);       check("srl_28",  dut_out(), lit(32'h0000_000F, 0, 0, 0, 0));

    // Reset has priority over an operation presented in the same cycle.
    rst = 1'b1;
    apply(32'd1, 32'd2, ALU_ADD); check("rst_discard", dut_out(), '0);
    rst = 1'b0;
    check("rst_hold", dut_out(), '0);
    @(posedge clk); #1;
    check("rst_release", dut_out(), lit(32'd3, 0, 0, 0, 0));

    // Back-to-back random ops with occasional corner operands.
    for (int i = 0; i < 1200; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   op;
      a  = $urandom;
      b  = $urandom;
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: a = 32'h7FFF_FFFF;
        2: b = a;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      apply(a, b, op);
      if (op != ALU_ADD && op != ALU_SUB)
        check("cv_zero", {{W{1'b0}}, 2'b00, bus.Carry, bus.OverFlow}, '0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu
